// File: rtl/core_pkg.sv
// Shared definitions for the RV32IM core pipeline.
// The fetch stage and its buffers use the entry layout defined here.
package core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count and synchronous clear.
// A push is accepted while full when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0],
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-2 depths stay in range.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues pipelined imem requests for the current PC,
// tags them in order, buffers returned words and squashes stale ones on flush.
module fetch_stage #(
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_INSTR       = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        pc_advance,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  import core_pkg::*;

  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int DCW = 8;

  // The tag queue occupancy is the live outstanding-request count.
  logic [OCW-1:0] out_cnt;
  logic           tag_full;
  logic           tag_empty;
  logic [31:0]    tag_pc;
  logic [DCW-1:0] drop_cnt;
  logic [FCW-1:0] fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  fetch_entry_t   head;
  fetch_entry_t   push_entry;
  logic           pop;
  logic           grant;
  logic           resp_keep;
  logic           mis_push;
  logic           fifo_push;
  logic           fault_pending;
  logic           aligned;
  logic [31:0]    credit_used;

  assign aligned     = (pc[1:0] == 2'b00);
  assign pop         = if_valid & id_ready;
  assign credit_used = 32'(out_cnt) + 32'(fifo_count) - 32'(pop);

  assign imem_req   = rst_n & ~flush & aligned & ~tag_full & (credit_used < 32'(FIFO_DEPTH));
  assign imem_addr  = pc;
  assign grant      = imem_req & imem_gnt;
  assign pc_advance = rst_n & (grant | flush);

  assign resp_keep = imem_rvalid & (drop_cnt == '0);
  // A misaligned PC yields a single fault entry until the trap redirect flushes.
  assign mis_push  = rst_n & ~flush & ~aligned & tag_empty & (drop_cnt == '0)
                   & ~fifo_full & ~fault_pending;
  assign fifo_push = resp_keep | mis_push;

  always_comb begin
    push_entry = '{pc: tag_pc, instr: imem_rdata, fault: 1'b0};
    if (!resp_keep) push_entry = '{pc: pc, instr: NOP_INSTR, fault: 1'b1};
  end

  fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (logic [31:0])
  ) u_tag_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (grant),
    .din   (pc),
    .pop   (resp_keep),
    .dout  (tag_pc),
    .count (out_cnt),
    .full  (tag_full),
    .empty (tag_empty)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fetch_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // On flush every live request becomes a drop, less any response landing now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt      <= '0;
      fault_pending <= 1'b0;
    end else begin
      if (flush)
        drop_cnt <= drop_cnt + DCW'(out_cnt) - DCW'(imem_rvalid);
      else if (imem_rvalid && drop_cnt != '0)
        drop_cnt <= drop_cnt - DCW'(1);

      if (flush)         fault_pending <= 1'b0;
      else if (mis_push) fault_pending <= 1'b1;
    end
  end

  assign if_valid = ~fifo_empty & ~flush;
  assign if_pc    = fifo_empty ? 32'h0 : head.pc;
  assign if_instr = fifo_empty ? NOP_INSTR : head.instr;
  assign if_fault = fifo_empty ? 1'b0 : head.fault;

endmodule
